mem_req_arb_2to1_4b: RTL and testbench
======================================

Name: mem_req_arb_2to1_4B

Overview:
- Shares one 4B memory request/response port, such as one port of the dual-ported test memory with random delays, between two independent requesters (e.g. instruction fetch and accelerator).
- Arbitrates requests round-robin and tags each forwarded request's opaque MSB with the requester index.
- Routes each response back by that tag, then clears the tag bit.
- Caps each requester's in-flight requests with a credit counter.

Parameters:
- p_opaque_nbits, 8, opaque field width. Requesters use only the low p_opaque_nbits-1 bits.
- p_max_outstanding, 4, max in-flight requests per requester (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req0_val/req0_rdy/req0_msg  in/out/in  1/1/77  requester 0 request (mem_req_4B_t).
- req1_val/req1_rdy/req1_msg  in/out/in  1/1/77  requester 1 request.
- resp0_val/resp0_rdy/resp0_msg  out/in/out  1/1/47  requester 0 response (mem_resp_4B_t).
- resp1_val/resp1_rdy/resp1_msg  out/in/out  1/1/47  requester 1 response.
- memreq_val/memreq_rdy/memreq_msg  out/in/out  1/1/77  to memory.
- memresp_val/memresp_rdy/memresp_msg  in/out/in  1/1/47  from memory.
- idle  out  1  both outstanding counters are zero.

Behaviour:
- Field layout:
  - Req: type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0].
  - Resp: type[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0].
- Reset (reset==0 at posedge): prio_ptr<=0, cnt0<=0, cnt1<=0.
  - During reset, all rdy and val outputs are forced 0. idle is 1 after reset.
- Eligibility: elig_i = req_i_val & (cnt_i < p_max_outstanding).
- Grant (combinational, one cycle, no pipeline register):
  - If both are eligible, grant port prio_ptr.
  - Otherwise grant the single eligible port; if none, no grant.
- memreq_val = elig of the granted port.
- memreq_msg = granted msg with opaque MSB (bit 73) replaced by the port index. All other bits pass unchanged.
- req_i_rdy = grant_i & memreq_rdy.
  - The non-granted port sees rdy=0.
  - rdy never asserts for an ineligible port.
- Req fire_i = req_i_val & req_i_rdy. At most one fires per cycle.
  - On fire, prio_ptr <= ~i, so the other port gets priority next.
  - With no fire, prio_ptr holds, including when memreq_val=1 but memreq_rdy=0. The grant may then change next cycle if eligibility changes; the message is not latched.
- Response routing: tag t = memresp_msg[43].
  - resp_t_val = memresp_val; resp_t_msg = memresp_msg with bit 43 cleared.
  - The other resp port has val=0. Its msg = the same cleared word, don't-care.
  - memresp_rdy = resp_t_rdy. Zero-latency combinational pass-through.
- Counters (width 4):
  - cnt_i increments on req fire_i and decrements on resp fire_i (resp_i_val & resp_i_rdy).
  - If both happen in the same cycle, cnt_i is unchanged.
  - Decrement at 0 saturates at 0: a stale response after a reset mid-operation is still delivered and must not underflow.
  - Increment beyond p_max_outstanding cannot occur, because eligibility blocks it.
- Credit-full: at cnt_i==max the port is blocked. A response fire in the same cycle does not unblock it until the next cycle; eligibility uses the registered cnt.
- idle = (cnt0==0)&(cnt1==0), registered-state based.
- Reset mid-operation clears all state. Requests already forwarded to memory are not cancelled.
- Line trace: prints "r0|r1>m" using the 4B req/resp trace helpers.

Test Plan:
- Single requester: req0 sends 3 reads addr 0x1000/0x1004/0x1008, opaque 0x05/0x06/0x07, with memreq_rdy=1.
  - memreq opaque = 0x05/0x06/0x07 (bit7=0).
  - Responses arrive on resp0 with opaque 0x05..0x07; resp1_val stays 0.
- Contention: both val=1 continuously with memreq_rdy=1.
  - Grants alternate 0,1,0,1 starting with port 0 after reset.
  - Port-1 memreq opaque = 0x80|orig.
- Backpressure: both val=1 with memreq_rdy=0 for 5 cycles.
  - No fires, prio_ptr held.
  - Then memreq_rdy=1: port 0 fires first, then port 1.
- Credit limit: p_max_outstanding=4, req0 streams with memresp withheld.
  - Exactly 4 fire, then req0_rdy=0 while req1 still proceeds.
  - After one resp0 fire, req0 fires again one cycle later.
- Response routing and backpressure: memresp opaque 0x83 with resp1_rdy=0 for 3 cycles.
  - memresp_rdy=0 for those cycles; resp1_val=1 with opaque 0x03.
  - It fires once resp1_rdy=1; cnt1 decrements.
- Reset mid-operation: reset=0 with cnt0=2.
  - Afterwards idle=1 and prio_ptr=0.
  - A late response tagged 0 is still delivered on resp0 and cnt0 stays 0.

Source files
------------

// File: rtl/mem_req_arb_2to1_4b.sv
// Two-to-one round-robin arbiter for a shared 4B memory request/response port.
// Requests are tagged with the requester index in the opaque MSB, and responses are routed back by that tag.
module mem_req_arb_2to1_4b #(
   parameter int p_opaque_nbits    = 8,
   parameter int p_max_outstanding = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_val,
   output logic        req0_rdy,
   input  logic [76:0] req0_msg,
   input  logic        req1_val,
   output logic        req1_rdy,
   input  logic [76:0] req1_msg,
   output logic        resp0_val,
   input  logic        resp0_rdy,
   output logic [46:0] resp0_msg,
   output logic        resp1_val,
   input  logic        resp1_rdy,
   output logic [46:0] resp1_msg,
   output logic        memreq_val,
   input  logic        memreq_rdy,
   output logic [76:0] memreq_msg,
   input  logic        memresp_val,
   output logic        memresp_rdy,
   input  logic [46:0] memresp_msg,
   output logic        idle
);

   localparam int          ReqOpqMsb  = 66 + p_opaque_nbits - 1;
   localparam int          RespOpqMsb = 36 + p_opaque_nbits - 1;
   localparam logic [3:0]  MaxOut     = 4'(p_max_outstanding);

   logic       prio_q, prio_d;
   logic [3:0] cnt0_q, cnt0_d;
   logic [3:0] cnt1_q, cnt1_d;
   logic       elig0_s, elig1_s;
   logic       grant0_s, grant1_s;
   logic       fire0_s, fire1_s;
   logic       rfire0_s, rfire1_s;
   logic       tag_s;
   logic [46:0] resp_clr_s;

   // Saturating up/down credit counter update; simultaneous inc and dec cancel.
   function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
      logic [3:0] nxt;
      nxt = cnt;
      case ({inc, dec})
         2'b10:   nxt = cnt + 4'd1;
         2'b01: begin
            if (cnt != 4'd0) begin
               nxt = cnt - 4'd1;
            end else begin
               nxt = cnt;
            end
         end
         default: nxt = cnt;
      endcase
      return nxt;
   endfunction

   // Eligibility, round-robin grant and request-side handshake.
   always_comb begin
      elig0_s  = req0_val & (cnt0_q < MaxOut);
      elig1_s  = req1_val & (cnt1_q < MaxOut);
      grant0_s = elig0_s & (~elig1_s | ~prio_q);
      grant1_s = elig1_s & (~elig0_s | prio_q);
      memreq_val = (grant0_s | grant1_s) & reset;
      req0_rdy   = grant0_s & memreq_rdy & reset;
      req1_rdy   = grant1_s & memreq_rdy & reset;
      fire0_s    = req0_val & req0_rdy;
      fire1_s    = req1_val & req1_rdy;
      memreq_msg = req0_msg;
      if (grant1_s) begin
         memreq_msg            = req1_msg;
         memreq_msg[ReqOpqMsb] = 1'b1;
      end else begin
         memreq_msg[ReqOpqMsb] = 1'b0;
      end
   end

   // Response steering by the opaque tag bit, which is cleared on the way back.
   always_comb begin
      tag_s                  = memresp_msg[RespOpqMsb];
      resp_clr_s             = memresp_msg;
      resp_clr_s[RespOpqMsb] = 1'b0;
      resp0_msg              = resp_clr_s;
      resp1_msg              = resp_clr_s;
      resp0_val              = memresp_val & ~tag_s & reset;
      resp1_val              = memresp_val & tag_s & reset;
      if (tag_s) begin
         memresp_rdy = resp1_rdy & reset;
      end else begin
         memresp_rdy = resp0_rdy & reset;
      end
      rfire0_s = resp0_val & resp0_rdy;
      rfire1_s = resp1_val & resp1_rdy;
   end

   // Next-state for priority pointer and credit counters.
   always_comb begin
      prio_d = prio_q;
      if (fire0_s) begin
         prio_d = 1'b1;
      end else if (fire1_s) begin
         prio_d = 1'b0;
      end else begin
         prio_d = prio_q;
      end
      cnt0_d = cnt_next(cnt0_q, fire0_s, rfire0_s);
      cnt1_d = cnt_next(cnt1_q, fire1_s, rfire1_s);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prio_q <= 1'b0;
         cnt0_q <= 4'd0;
         cnt1_q <= 4'd0;
      end else begin
         prio_q <= prio_d;
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign idle = (cnt0_q == 4'd0) & (cnt1_q == 4'd0);

endmodule

// File: tb/tb_mem_req_arb_2to1_4b.sv
// Directed table-driven bench for the 2:1 memory request arbiter.
module tb_mem_req_arb_2to1_4b;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam logic [31:0] A = 32'h0000_1000;

   logic        clk;
   logic        reset;
   logic        req0_val, req0_rdy, req1_val, req1_rdy;
   logic [76:0] req0_msg, req1_msg, memreq_msg;
   logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
   logic [46:0] resp0_msg, resp1_msg, memresp_msg;
   logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy, idle;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        r0v;
      logic [6:0]  r0opq;
      logic [31:0] r0addr;
      logic        r1v;
      logic [6:0]  r1opq;
      logic        mrdy;
      logic        mrv;
      logic [7:0]  mropq;
      logic        s0rdy;
      logic        s1rdy;
      logic        e_r0rdy;
      logic        e_r1rdy;
      logic        e_mval;
      logic        e_gnt;
      logic [7:0]  e_mopq;
      logic        e_mrrdy;
      logic        e_s0v;
      logic        e_s1v;
      logic [7:0]  e_sopq;
      logic        e_idle;
   } vec_t;

   vec_t vecs[$];

   mem_req_arb_2to1_4b #(.p_opaque_nbits(8), .p_max_outstanding(4)) dut (
      .clk(clk), .reset(reset),
      .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
      .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
      .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
      .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
      .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
      .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
      .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                                          input logic [1:0] l, input logic [31:0] d);
      return {t, o, a, l, d};
   endfunction

   function automatic logic [46:0] mk_resp(input logic [2:0] t, input logic [7:0] o, input logic [1:0] ts,
                                           input logic [1:0] l, input logic [31:0] d);
      return {t, o, ts, l, d};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      reset       = v.rst;
      req0_val    = v.r0v;
      req0_msg    = mk_req(3'd0, {1'b1, v.r0opq}, v.r0addr, 2'd0, 32'h0000_0000);
      req1_val    = v.r1v;
      req1_msg    = mk_req(3'd1, {1'b0, v.r1opq}, 32'h0000_2000, 2'd3, 32'hA5A5_A5A5);
      memreq_rdy  = v.mrdy;
      memresp_val = v.mrv;
      memresp_msg = mk_resp(3'd0, v.mropq, 2'd1, 2'd2, {24'hCAFE00, v.mropq});
      resp0_rdy   = v.s0rdy;
      resp1_rdy   = v.s1rdy;
   endtask

   task automatic check_vec(input int n, input vec_t v);
      logic [76:0] exp_req;
      logic [46:0] exp_resp;
      exp_resp = mk_resp(3'd0, v.e_sopq, 2'd1, 2'd2, {24'hCAFE00, v.mropq});
      if (v.e_gnt) begin
         exp_req = mk_req(3'd1, v.e_mopq, 32'h0000_2000, 2'd3, 32'hA5A5_A5A5);
      end else begin
         exp_req = mk_req(3'd0, v.e_mopq, v.r0addr, 2'd0, 32'h0000_0000);
      end
      chk($sformatf("v%0d req0_rdy", n), 128'(req0_rdy), 128'(v.e_r0rdy));
      chk($sformatf("v%0d req1_rdy", n), 128'(req1_rdy), 128'(v.e_r1rdy));
      chk($sformatf("v%0d memreq_val", n), 128'(memreq_val), 128'(v.e_mval));
      chk($sformatf("v%0d memresp_rdy", n), 128'(memresp_rdy), 128'(v.e_mrrdy));
      chk($sformatf("v%0d resp0_val", n), 128'(resp0_val), 128'(v.e_s0v));
      chk($sformatf("v%0d resp1_val", n), 128'(resp1_val), 128'(v.e_s1v));
      chk($sformatf("v%0d idle", n), 128'(idle), 128'(v.e_idle));
      if (v.e_mval) chk($sformatf("v%0d memreq_msg", n), 128'(memreq_msg), 128'(exp_req));
      if (v.e_s0v) chk($sformatf("v%0d resp0_msg", n), 128'(resp0_msg), 128'(exp_resp));
      if (v.e_s1v) chk($sformatf("v%0d resp1_msg", n), 128'(resp1_msg), 128'(exp_resp));
   endtask

   initial begin
      vec_t v;
      // Fields: rst r0v r0opq r0addr r1v r1opq mrdy mrv mropq s0rdy s1rdy | r0rdy r1rdy mval gnt mopq mrrdy s0v s1v sopq idle
      vecs.push_back('{L, H, 7'h05, A, H, 7'h21, H, H, 8'h05, H, H,  L, L, L, L, 8'h00, L, L, L, 8'h00, H});
      // single requester, three reads
      vecs.push_back('{H, H, 7'h05, 32'h1000, L, 7'h21, H, L, 8'h00, H, H,  H, L, H, L, 8'h05, H, L, L, 8'h00, H});
      vecs.push_back('{H, H, 7'h06, 32'h1004, L, 7'h21, H, L, 8'h00, H, H,  H, L, H, L, 8'h06, H, L, L, 8'h00, L});
      vecs.push_back('{H, H, 7'h07, 32'h1008, L, 7'h21, H, L, 8'h00, H, H,  H, L, H, L, 8'h07, H, L, L, 8'h00, L});
      vecs.push_back('{H, L, 7'h07, A, L, 7'h21, H, H, 8'h05, H, H,  L, L, L, L, 8'h00, H, H, L, 8'h05, L});
      vecs.push_back('{H, L, 7'h07, A, L, 7'h21, H, H, 8'h06, H, H,  L, L, L, L, 8'h00, H, H, L, 8'h06, L});
      vecs.push_back('{H, L, 7'h07, A, L, 7'h21, H, H, 8'h07, H, H,  L, L, L, L, 8'h00, H, H, L, 8'h07, L});
      // reset then contention: 0,1,0,1
      vecs.push_back('{L, H, 7'h10, A, H, 7'h21, H, L, 8'h00, H, H,  L, L, L, L, 8'h00, L, L, L, 8'h00, H});
      for (int i = 0; i < 2; i++) begin
         vecs.push_back('{H, H, 7'h10, A, H, 7'h21, H, L, 8'h00, H, H,  H, L, H, L, 8'h10, H, L, L, 8'h00, (i == 0) ? H : L});
         vecs.push_back('{H, H, 7'h10, A, H, 7'h21, H, L, 8'h00, H, H,  L, H, H, H, 8'hA1, H, L, L, 8'h00, L});
      end
      // backpressure for five cycles, priority held at port 0
      for (int i = 0; i < 5; i++)
         vecs.push_back('{H, H, 7'h10, A, H, 7'h21, L, L, 8'h00, H, H,  L, L, H, L, 8'h10, H, L, L, 8'h00, L});
      vecs.push_back('{H, H, 7'h10, A, H, 7'h21, H, L, 8'h00, H, H,  H, L, H, L, 8'h10, H, L, L, 8'h00, L});
      vecs.push_back('{H, H, 7'h10, A, H, 7'h21, H, L, 8'h00, H, H,  L, H, H, H, 8'hA1, H, L, L, 8'h00, L});
      // credit limit: cnt0 reaches 4, port 1 still proceeds
      vecs.push_back('{H, H, 7'h10, A, L, 7'h21, H, L, 8'h00, H, H,  H, L, H, L, 8'h10, H, L, L, 8'h00, L});
      vecs.push_back('{H, H, 7'h10, A, H, 7'h21, H, L, 8'h00, H, H,  L, H, H, H, 8'hA1, H, L, L, 8'h00, L});
      vecs.push_back('{H, H, 7'h10, A, L, 7'h21, H, H, 8'h10, H, H,  L, L, L, L, 8'h00, H, H, L, 8'h10, L});
      vecs.push_back('{H, H, 7'h10, A, L, 7'h21, H, L, 8'h00, H, H,  H, L, H, L, 8'h10, H, L, L, 8'h00, L});
      // response to port 1 held by resp1_rdy=0
      for (int i = 0; i < 3; i++)
         vecs.push_back('{H, L, 7'h10, A, L, 7'h21, H, H, 8'h83, H, L,  L, L, L, L, 8'h00, L, L, H, 8'h03, L});
      vecs.push_back('{H, L, 7'h10, A, L, 7'h21, H, H, 8'h83, H, H,  L, L, L, L, 8'h00, H, L, H, 8'h03, L});
      vecs.push_back('{H, L, 7'h10, A, H, 7'h21, H, L, 8'h00, H, H,  L, H, H, H, 8'hA1, H, L, L, 8'h00, L});
      // drain cnt0 to 2, reset mid-operation, late response to port 0
      vecs.push_back('{H, L, 7'h10, A, L, 7'h21, H, H, 8'h10, H, H,  L, L, L, L, 8'h00, H, H, L, 8'h10, L});
      vecs.push_back('{H, L, 7'h10, A, L, 7'h21, H, H, 8'h10, H, H,  L, L, L, L, 8'h00, H, H, L, 8'h10, L});
      vecs.push_back('{L, H, 7'h10, A, H, 7'h21, H, H, 8'h10, H, H,  L, L, L, L, 8'h00, L, L, L, 8'h00, L});
      vecs.push_back('{H, L, 7'h10, A, L, 7'h21, H, H, 8'h05, H, H,  L, L, L, L, 8'h00, H, H, L, 8'h05, H});
      vecs.push_back('{H, H, 7'h10, A, H, 7'h21, H, L, 8'h00, H, H,  H, L, H, L, 8'h10, H, L, L, 8'h00, H});
      vecs.push_back('{H, H, 7'h10, A, H, 7'h21, H, L, 8'h00, H, H,  L, H, H, H, 8'hA1, H, L, L, 8'h00, L});

      // initial reset so counters start defined
      v = vecs[0];
      apply(v);
      repeat (2) @(posedge clk);
      #1;

      for (int n = 0; n < vecs.size(); n++) begin
         apply(vecs[n]);
         #2;
         check_vec(n, vecs[n]);
         @(posedge clk);
         #1;
      end

      // Stalled grant is not latched: dropping req0 moves the grant to port 1.
      v = '{H, H, 7'h10, A, H, 7'h21, L, L, 8'h00, H, H,  L, L, H, L, 8'h10, H, L, L, 8'h00, L};
      apply(v);
      #2;
      check_vec(100, v);
      @(posedge clk);
      #1;
      v = '{H, L, 7'h10, A, H, 7'h21, L, L, 8'h00, H, H,  L, L, H, H, 8'hA1, H, L, L, 8'h00, L};
      apply(v);
      #2;
      check_vec(101, v);
      @(posedge clk);
      #1;
      v = '{H, L, 7'h10, A, H, 7'h21, H, L, 8'h00, H, H,  L, H, H, H, 8'hA1, H, L, L, 8'h00, L};
      apply(v);
      #2;
      check_vec(102, v);
      @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
